// File: rtl/i2c_txn_ctrl_pkg.sv
// rtl/i2c_txn_ctrl_pkg.sv - shared types for the I2C transaction sequencer
// Purpose: command, status and state encodings used by i2c_txn_ctrl and its
//          command-port handshake block, plus the address-byte helper.
// Ports:   none (package)
package i2c_txn_ctrl_pkg;

  // {m_start, m_stop} encoding understood by the byte-level master
  typedef enum logic [1:0] {
    CMD_WRITE = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_START = 2'b10,
    CMD_READ  = 2'b11
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    STS_OK        = 2'b00,
    STS_ADDR_NACK = 2'b01,
    STS_DATA_NACK = 2'b10,
    STS_TIMEOUT   = 2'b11
  } i2c_status_t;

  typedef enum logic [2:0] {
    TS_IDLE,
    TS_START,
    TS_ADDR,
    TS_WDATA,
    TS_RDATA,
    TS_STOP,
    TS_NACKWAIT,
    TS_DONE
  } txn_state_t;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_ISSUE,
    CS_WAIT
  } cmd_state_t;

  // First byte on the bus: 7-bit address followed by the R/W bit
  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_txn_ctrl_cmd_if.sv
// rtl/i2c_txn_ctrl_cmd_if.sv - one-command handshake with the byte-level master
// Purpose: takes a single command (cmd/data/ack + go pulse), strobes it into the
//          master, waits for the master to come back ready and reports the result.
//          A per-command cycle counter aborts a command that never completes.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   go                    1-cycle request to issue cmd (only honoured when idle)
//   cmd, data, ack        command select, byte to send, ACK select for READ
//   cmd_done              1-cycle pulse, command completed
//   nack                  valid with cmd_done: slave NACKed the written byte
//   rx_byte               byte captured from the master on m_tx_done
//   timeout               1-cycle pulse, command abandoned after TIMEOUT_CYC cycles
//   m_en/m_start/m_stop/m_ack/m_tx_data   master command port (registered)
//   m_tx_ready/m_tx_done/m_rx_done/m_rx_data  master status inputs
module i2c_txn_ctrl_cmd_if
  import i2c_txn_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  i2c_cmd_t   cmd,
  input  logic [7:0] data,
  input  logic       ack,
  output logic       cmd_done,
  output logic       nack,
  output logic [7:0] rx_byte,
  output logic       timeout,
  output logic       m_en,
  output logic       m_start,
  output logic       m_stop,
  output logic       m_ack,
  output logic [7:0] m_tx_data,
  input  logic       m_tx_ready,
  input  logic       m_tx_done,
  input  logic       m_rx_done,
  input  logic [7:0] m_rx_data
);

  localparam int            TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYC - 1);

  cmd_state_t    state;
  logic [TW-1:0] tcnt;
  logic          nack_lat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CS_IDLE;
      tcnt      <= '0;
      nack_lat  <= 1'b0;
      cmd_done  <= 1'b0;
      nack      <= 1'b0;
      rx_byte   <= 8'h00;
      timeout   <= 1'b0;
      m_en      <= 1'b0;
      m_start   <= 1'b0;
      m_stop    <= 1'b0;
      m_ack     <= 1'b0;
      m_tx_data <= 8'h00;
    end else begin
      cmd_done <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        CS_IDLE: begin
          if (go) begin
            {m_start, m_stop} <= cmd;
            m_tx_data         <= data;
            m_ack             <= ack;
            m_en              <= 1'b1;
            tcnt              <= '0;
            nack_lat          <= 1'b0;
            state             <= CS_ISSUE;
          end
        end
        // Keep strobing until the master drops ready: from IDLE the first
        // strobe only moves it to HOLD, the second actually starts the byte.
        CS_ISSUE: begin
          if (!m_tx_ready) begin
            m_en  <= 1'b0;
            tcnt  <= tcnt + TW'(1);
            state <= CS_WAIT;
          end else if (tcnt == T_LIM) begin
            m_en    <= 1'b0;
            timeout <= 1'b1;
            state   <= CS_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CS_WAIT: begin
          if (m_tx_done) begin
            nack_lat <= m_rx_done;
            rx_byte  <= m_rx_data;
          end
          // m_tx_done may coincide with ready returning; use the live value then
          if (m_tx_ready) begin
            cmd_done <= 1'b1;
            nack     <= m_tx_done ? m_rx_done : nack_lat;
            state    <= CS_IDLE;
          end else if (tcnt == T_LIM) begin
            timeout <= 1'b1;
            state   <= CS_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= CS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/i2c_txn_ctrl.sv
// rtl/i2c_txn_ctrl.sv - I2C transaction sequencer in front of the byte master
// Purpose: accepts one request (addr, R/W, length) and walks the master through
//          START, address byte, length data bytes and STOP, streaming write bytes
//          in and read bytes out, then pulses done with a status code.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr/req_rw/req_len   transaction request
//   wr_data/wr_valid/wr_ready          write byte stream in
//   rd_data/rd_valid/rd_ready          read byte stream out
//   done, status                       completion pulse and result code
//   m_en/m_start/m_stop/m_ack/m_tx_data            master command port
//   m_tx_ready/m_tx_done/m_rx_done/m_rx_data       master status
module i2c_txn_ctrl
  import i2c_txn_ctrl_pkg::*;
#(
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic             req_rw,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             done,
  output logic [1:0]       status,
  output logic             m_en,
  output logic             m_start,
  output logic             m_stop,
  output logic             m_ack,
  output logic [7:0]       m_tx_data,
  input  logic             m_tx_ready,
  input  logic             m_tx_done,
  input  logic             m_rx_done,
  input  logic [7:0]       m_rx_data
);

  txn_state_t       state;
  i2c_status_t      status_q;
  logic [6:0]       addr_q;
  logic             rw_q;
  logic [LEN_W-1:0] byte_cnt;

  // Request to the command block; issued stays high until it reports back
  logic       go;
  logic       issued;
  i2c_cmd_t   cmd_q;
  logic [7:0] cmd_data;
  logic       cmd_ack;

  logic       cmd_done;
  logic       cmd_nack;
  logic [7:0] rx_byte;
  logic       timeout;

  assign status = status_q;

  // A write byte is taken only in the cycle the next WRITE gets launched
  assign wr_ready = (state == TS_WDATA) && !issued && wr_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= TS_IDLE;
      status_q  <= STS_OK;
      addr_q    <= 7'h00;
      rw_q      <= 1'b0;
      byte_cnt  <= '0;
      go        <= 1'b0;
      issued    <= 1'b0;
      cmd_q     <= CMD_WRITE;
      cmd_data  <= 8'h00;
      cmd_ack   <= 1'b0;
      req_ready <= 1'b1;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      go   <= 1'b0;
      done <= 1'b0;
      if (timeout) begin
        issued   <= 1'b0;
        status_q <= STS_TIMEOUT;
        done     <= 1'b1;
        state    <= TS_DONE;
      end else begin
        case (state)
          TS_IDLE: begin
            if (req_valid) begin
              addr_q    <= req_addr;
              rw_q      <= req_rw;
              byte_cnt  <= req_len;
              status_q  <= STS_OK;
              req_ready <= 1'b0;
              state     <= TS_START;
            end
          end
          TS_START: begin
            if (!issued) begin
              go       <= 1'b1;
              issued   <= 1'b1;
              cmd_q    <= CMD_START;
              cmd_data <= 8'h00;
              cmd_ack  <= 1'b0;
            end else if (cmd_done) begin
              issued <= 1'b0;
              state  <= TS_ADDR;
            end
          end
          TS_ADDR: begin
            if (!issued) begin
              go       <= 1'b1;
              issued   <= 1'b1;
              cmd_q    <= CMD_WRITE;
              cmd_data <= addr_byte(addr_q, rw_q);
              cmd_ack  <= 1'b0;
            end else if (cmd_done) begin
              issued <= 1'b0;
              if (cmd_nack) begin
                status_q <= STS_ADDR_NACK;
                state    <= TS_NACKWAIT;
              end else if (byte_cnt == '0) begin
                state <= TS_STOP;
              end else begin
                state <= rw_q ? TS_RDATA : TS_WDATA;
              end
            end
          end
          TS_WDATA: begin
            if (!issued) begin
              // No write byte available: simply wait, the master holds SCL low
              if (wr_valid) begin
                go       <= 1'b1;
                issued   <= 1'b1;
                cmd_q    <= CMD_WRITE;
                cmd_data <= wr_data;
                cmd_ack  <= 1'b0;
              end
            end else if (cmd_done) begin
              issued <= 1'b0;
              if (cmd_nack) begin
                status_q <= STS_DATA_NACK;
                state    <= TS_NACKWAIT;
              end else begin
                byte_cnt <= byte_cnt - LEN_W'(1);
                if (byte_cnt == LEN_W'(1)) state <= TS_STOP;
              end
            end
          end
          TS_RDATA: begin
            // The next READ waits until the previous byte has been taken
            if (rd_valid) begin
              if (rd_ready) begin
                rd_valid <= 1'b0;
                if (byte_cnt == '0) state <= TS_STOP;
              end
            end else if (!issued) begin
              go       <= 1'b1;
              issued   <= 1'b1;
              cmd_q    <= CMD_READ;
              cmd_data <= 8'h00;
              cmd_ack  <= (byte_cnt != LEN_W'(1));
            end else if (cmd_done) begin
              issued   <= 1'b0;
              rd_data  <= rx_byte;
              rd_valid <= 1'b1;
              byte_cnt <= byte_cnt - LEN_W'(1);
            end
          end
          TS_STOP: begin
            if (!issued) begin
              go       <= 1'b1;
              issued   <= 1'b1;
              cmd_q    <= CMD_STOP;
              cmd_data <= 8'h00;
              cmd_ack  <= 1'b0;
            end else if (cmd_done) begin
              issued <= 1'b0;
              done   <= 1'b1;
              state  <= TS_DONE;
            end
          end
          // After a NACK the master generates STOP by itself
          TS_NACKWAIT: begin
            if (m_tx_ready) begin
              done  <= 1'b1;
              state <= TS_DONE;
            end
          end
          TS_DONE: begin
            req_ready <= 1'b1;
            state     <= TS_IDLE;
          end
          default: state <= TS_IDLE;
        endcase
      end
    end
  end

  i2c_txn_ctrl_cmd_if #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_cmd_if (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .cmd        (cmd_q),
    .data       (cmd_data),
    .ack        (cmd_ack),
    .cmd_done   (cmd_done),
    .nack       (cmd_nack),
    .rx_byte    (rx_byte),
    .timeout    (timeout),
    .m_en       (m_en),
    .m_start    (m_start),
    .m_stop     (m_stop),
    .m_ack      (m_ack),
    .m_tx_data  (m_tx_data),
    .m_tx_ready (m_tx_ready),
    .m_tx_done  (m_tx_done),
    .m_rx_done  (m_rx_done),
    .m_rx_data  (m_rx_data)
  );

endmodule

// File: tb/tb_i2c_txn_ctrl.sv
// tb/tb_i2c_txn_ctrl.sv - scoreboard bench with behavioural master and slave at 0x50
module tb_i2c_txn_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_rw;
  logic [6:0] req_addr;
  logic [3:0] req_len;
  logic [7:0] wr_data, rd_data, m_tx_data, m_rx_data;
  logic       wr_valid, wr_ready, rd_valid, rd_ready, done;
  logic [1:0] status;
  logic       m_en, m_start, m_stop, m_ack, m_tx_ready, m_tx_done, m_rx_done;

  always #5 clk = ~clk;

  i2c_txn_ctrl #(.LEN_W(4), .TIMEOUT_CYC(200)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .status(status),
    .m_en(m_en), .m_start(m_start), .m_stop(m_stop), .m_ack(m_ack),
    .m_tx_data(m_tx_data), .m_tx_ready(m_tx_ready), .m_tx_done(m_tx_done),
    .m_rx_done(m_rx_done), .m_rx_data(m_rx_data)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Scoreboard queues filled by the reference model when a request is issued
  logic [11:0] exp_bus[$];
  logic [7:0]  exp_rd[$];
  logic [1:0]  exp_st[$];
  logic [7:0]  wr_q[$];
  logic [7:0]  slave_rd_q[$];
  logic [7:0]  fixed_q[$];

  int slave_nack_idx = -1;
  int slave_byte_idx = -1;
  bit bus_check_en = 1'b1;
  bit mst_hang = 1'b0;
  bit mst_idle;
  bit rd_hold = 1'b0;
  int n_done = 0;
  int n_wr_acc = 0;
  int n_bus_ev = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got %s", name, what);
  endtask

  // Bus event: {type, ack, byte}; 1 START, 2 WRITE, 3 READ, 4 STOP
  function automatic logic [11:0] ev(input int t, input logic a, input logic [7:0] d);
    return {t[2:0], a, d};
  endfunction

  task automatic log_ev(input logic [11:0] e);
    n_bus_ev++;
    if (bus_check_en) begin
      if (exp_bus.size() == 0) fail_now("bus_event", $sformatf("%0h expected none", e));
      else check("bus_event", e, exp_bus.pop_front());
    end
  endtask

  // Behavioural byte master with the slave folded in
  initial begin : mst_model
    logic [1:0] c;
    logic [7:0] d;
    logic [7:0] rb;
    logic       a;
    bit         nk;
    bit         aborted;
    int         n;
    m_tx_ready = 1'b1;
    m_tx_done  = 1'b0;
    m_rx_done  = 1'b0;
    m_rx_data  = 8'h00;
    mst_idle   = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tx_done = 1'b0;
      m_rx_done = 1'b0;
      if (reset) begin
        m_tx_ready = 1'b1;
        mst_idle   = 1'b1;
      end else if (m_en && m_tx_ready) begin
        if (mst_idle) begin
          mst_idle = 1'b0;
        end else begin
          c = {m_start, m_stop};
          d = m_tx_data;
          a = m_ack;
          m_tx_ready = 1'b0;
          nk = 1'b0;
          rb = 8'h00;
          case (c)
            2'b10: begin log_ev(ev(1, 1'b0, 8'h00)); slave_byte_idx = -1; end
            2'b00: begin
              log_ev(ev(2, 1'b0, d));
              if (slave_byte_idx < 0) nk = (d[7:1] != 7'h50);
              else nk = (slave_byte_idx == slave_nack_idx);
              slave_byte_idx++;
            end
            2'b11: begin
              log_ev(ev(3, a, 8'h00));
              rb = (slave_rd_q.size() > 0) ? slave_rd_q.pop_front() : 8'hFF;
            end
            default: log_ev(ev(4, 1'b0, 8'h00));
          endcase
          aborted = 1'b0;
          if (mst_hang) begin
            while (!reset) @(posedge clk);
            #1;
            aborted = 1'b1;
          end else begin
            n = $urandom_range(2, 6);
            for (int k = 0; k < n && !aborted; k++) begin
              @(posedge clk); #1;
              if (reset) aborted = 1'b1;
            end
          end
          if (aborted) begin
            m_tx_ready = 1'b1;
            mst_idle   = 1'b1;
          end else if (c == 2'b00 || c == 2'b11) begin
            m_tx_done = 1'b1;
            m_rx_done = nk;
            m_rx_data = rb;
            if (nk) begin
              repeat (3) begin @(posedge clk); #1; m_tx_done = 1'b0; m_rx_done = 1'b0; end
              m_tx_ready = 1'b1;
              mst_idle   = 1'b1;
            end else if ($urandom_range(0, 1) == 1) begin
              @(posedge clk); #1;
              m_tx_done  = 1'b0;
              m_rx_done  = 1'b0;
              m_tx_ready = 1'b1;
            end else begin
              m_tx_ready = 1'b1;
            end
          end else begin
            m_tx_ready = 1'b1;
            if (c == 2'b01) mst_idle = 1'b1;
          end
        end
      end
    end
  end

  // Write-byte source with random gaps
  initial begin : wr_drv
    bit hs;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    forever begin
      @(negedge clk);
      hs = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (hs) begin
        if (wr_q.size() > 0) void'(wr_q.pop_front());
        n_wr_acc++;
      end
      if (wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        wr_valid = 1'b1;
        wr_data  = wr_q[0];
      end else begin
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
      end
    end
  end

  initial begin : rd_drv
    rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rd_ready = rd_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares read bytes and completion status as the DUT presents them
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) fail_now("rd_data", $sformatf("%0h expected none", rd_data));
        else check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        if (exp_st.size() == 0) fail_now("status", $sformatf("%0h expected no done", status));
        else check("status", status, exp_st.pop_front());
        check("done_single_cycle", prev_done, 1'b0);
        n_done++;
      end
      prev_done = done;
    end
  end

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_status", status, 2'b00);
    check("rst_m_en", m_en, 1'b0);
    check("rst_m_start", m_start, 1'b0);
    check("rst_m_stop", m_stop, 1'b0);
    check("rst_m_ack", m_ack, 1'b0);
    check("rst_m_tx_data", m_tx_data, 8'h00);
  endtask

  task automatic issue_req(input logic [6:0] a, input bit rw, input int len);
    for (int k = 0; k < 1000 && !req_ready; k++) begin @(posedge clk); #1; end
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    req_rw    = rw;
    req_len   = 4'(len);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 7'($urandom);
    req_rw    = 1'($urandom);
    req_len   = 4'($urandom);
  endtask

  task automatic wait_done(input int start_done, input int budget);
    int cyc;
    cyc = 0;
    while (n_done == start_done && cyc < budget) begin @(posedge clk); cyc++; end
    if (n_done == start_done) fail_now("txn_done_wait", "no done within budget");
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference model: bus sequence, read bytes, accepted writes and status
  task automatic run_txn(input logic [6:0] a, input bit rw, input int len,
                         input int nk_idx, input bit stall);
    logic [7:0] b;
    int exp_acc;
    int st;
    int start_done;
    exp_acc = 0;
    st = 0;
    slave_nack_idx = nk_idx;
    exp_bus.push_back(ev(1, 1'b0, 8'h00));
    exp_bus.push_back(ev(2, 1'b0, {a, rw}));
    if (a != 7'h50) begin
      st = 1;
    end else if (!rw) begin
      for (int i = 0; i < len; i++) begin
        b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
        wr_q.push_back(b);
        if (st == 0) begin
          exp_bus.push_back(ev(2, 1'b0, b));
          exp_acc++;
          if (i == nk_idx) st = 2;
        end
      end
      if (st == 0) exp_bus.push_back(ev(4, 1'b0, 8'h00));
    end else begin
      for (int i = 0; i < len; i++) begin
        b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
        slave_rd_q.push_back(b);
        exp_rd.push_back(b);
        exp_bus.push_back(ev(3, (i != len - 1), 8'h00));
      end
      exp_bus.push_back(ev(4, 1'b0, 8'h00));
    end
    exp_st.push_back(2'(st));
    n_wr_acc = 0;
    start_done = n_done;
    rd_hold = stall;
    issue_req(a, rw, len);
    if (stall) begin
      repeat (1000) @(posedge clk);
      #1;
      rd_hold = 1'b0;
    end
    wait_done(start_done, 5000);
    check("wr_accepts", n_wr_acc, exp_acc);
    check("bus_events_left", exp_bus.size(), 0);
    check("rd_bytes_left", exp_rd.size(), 0);
    check("req_ready_after", req_ready, 1'b1);
    wr_q.delete();
    slave_rd_q.delete();
    exp_bus.delete();
    exp_rd.delete();
  endtask

  initial begin : main
    logic [6:0] ra;
    bit         rrw;
    int         rlen;
    int         rnk;
    int         start_done;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 7'h00;
    req_rw    = 1'b0;
    req_len   = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    fixed_q = '{8'hA5, 8'h3C};
    run_txn(7'h50, 1'b0, 2, -1, 1'b0);
    fixed_q = '{8'h11, 8'h22, 8'h33};
    run_txn(7'h50, 1'b1, 3, -1, 1'b0);
    run_txn(7'h51, 1'b0, 0, -1, 1'b0);
    run_txn(7'h50, 1'b0, 2, 0, 1'b0);
    run_txn(7'h50, 1'b1, 2, -1, 1'b1);
    run_txn(7'h50, 1'b0, 15, -1, 1'b0);
    run_txn(7'h50, 1'b1, 0, -1, 1'b0);

    // Master hangs on START: the command must time out with status 11
    mst_hang = 1'b1;
    exp_bus.push_back(ev(1, 1'b0, 8'h00));
    exp_st.push_back(2'b11);
    start_done = n_done;
    issue_req(7'h50, 1'b0, 1);
    wait_done(start_done, 1000);
    check("timeout_bus_left", exp_bus.size(), 0);
    check("timeout_m_en", m_en, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    mst_hang = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while stalled in WDATA waiting for a write byte
    bus_check_en = 1'b0;
    slave_nack_idx = -1;
    n_bus_ev = 0;
    issue_req(7'h50, 1'b0, 3);
    for (int k = 0; k < 500 && n_bus_ev < 2; k++) begin @(posedge clk); #1; end
    check("mid_wdata_bus_events", n_bus_ev, 2);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus_check_en = 1'b1;

    for (int t = 0; t < 25; t++) begin
      ra = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h50;
      if (ra == 7'h50 && $urandom_range(0, 4) == 0) ra = 7'h51;
      rrw  = 1'($urandom);
      rlen = $urandom_range(0, 6);
      rnk  = (!rrw && rlen > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, rlen - 1) : -1;
      run_txn(ra, rrw, rlen, rnk, 1'b0);
    end

    check("status_queue_left", exp_st.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
